// File: rtl/brc_pipe.sv
// brc_pipe: pipelined branch comparator and taken resolver.
// SPLIT=0 resolves in one registered stage; SPLIT=1 compares the operand
// halves in stage 1 and merges them in stage 2 to shorten the compare path.
// XLEN must be even and at least 4.
module brc_pipe #(
  parameter int XLEN  = 32,
  parameter int SPLIT = 0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  output logic            o_valid,
  output logic            o_br_equal,
  output logic            o_br_less,
  output logic            o_br_taken,
  output logic            o_illegal
);

  localparam int HALF = XLEN / 2;

  // Full-width less-than; uns selects unsigned, otherwise two's complement.
  function automatic logic lt_full(input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b,
                                   input logic            uns);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    sa = a;
    sb = b;
    if (uns) return (a < b);
    return (sa < sb);
  endfunction

  // Half-width less-than; the low half is always called with uns=1.
  function automatic logic lt_half(input logic [HALF-1:0] a,
                                   input logic [HALF-1:0] b,
                                   input logic            uns);
    logic signed [HALF-1:0] sa;
    logic signed [HALF-1:0] sb;
    sa = a;
    sb = b;
    if (uns) return (a < b);
    return (sa < sb);
  endfunction

  // Returns {taken, illegal} for a funct3 code and its compare flags.
  function automatic logic [1:0] resolve(input logic [2:0] f3,
                                         input logic       eq,
                                         input logic       lt);
    logic [1:0] r;
    r = 2'b00;
    case (f3)
      3'b000:         r = {eq, 1'b0};
      3'b001:         r = {~eq, 1'b0};
      3'b100, 3'b110: r = {lt, 1'b0};
      3'b101, 3'b111: r = {~lt, 1'b0};
      default:        r = 2'b01;
    endcase
    return r;
  endfunction

  logic            accept;
  logic            uns_mode;
  logic            res_vld;
  logic            res_eq;
  logic            res_lt;
  logic [2:0]      res_f3;
  logic [1:0]      dec;

  assign accept   = i_valid & ~i_stall & ~i_flush;
  assign uns_mode = i_funct3[1];

  if (SPLIT == 0) begin : g_single
    logic       vld_p1;
    logic       eq_p1;
    logic       lt_p1;
    logic [2:0] f3_p1;

    // ---- stage 1: full-width compare ----
    // Valid bit: flush beats stall, stall holds, otherwise take i_valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)     vld_p1 <= 1'b0;
      else if (i_flush) vld_p1 <= 1'b0;
      else if (!i_stall) vld_p1 <= i_valid;
    end

    // Compare results are captured only on an accepting edge.
    always_ff @(posedge i_clk) begin
      if (accept) begin
        eq_p1 <= (i_rs1_data == i_rs2_data);
        lt_p1 <= lt_full(i_rs1_data, i_rs2_data, uns_mode);
        f3_p1 <= i_funct3;
      end
    end

    assign res_vld = vld_p1;
    assign res_eq  = eq_p1;
    assign res_lt  = lt_p1;
    assign res_f3  = f3_p1;
  end else begin : g_split
    logic       vld_p1;
    logic       eq_hi_p1;
    logic       eq_lo_p1;
    logic       lt_hi_p1;
    logic       lt_lo_p1;
    logic [2:0] f3_p1;
    logic       vld_p2;
    logic       eq_p2;
    logic       lt_p2;
    logic [2:0] f3_p2;

    // ---- stage 1: per-half compare ----
    // Valid bits for both stages: flush beats stall, stall holds.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        vld_p1 <= 1'b0;
        vld_p2 <= 1'b0;
      end else if (i_flush) begin
        vld_p1 <= 1'b0;
        vld_p2 <= 1'b0;
      end else if (!i_stall) begin
        vld_p1 <= i_valid;
        vld_p2 <= vld_p1;
      end
    end

    // Upper half follows the branch mode; lower half is a plain magnitude.
    always_ff @(posedge i_clk) begin
      if (accept) begin
        eq_hi_p1 <= (i_rs1_data[XLEN-1:HALF] == i_rs2_data[XLEN-1:HALF]);
        eq_lo_p1 <= (i_rs1_data[HALF-1:0] == i_rs2_data[HALF-1:0]);
        lt_hi_p1 <= lt_half(i_rs1_data[XLEN-1:HALF], i_rs2_data[XLEN-1:HALF], uns_mode);
        lt_lo_p1 <= lt_half(i_rs1_data[HALF-1:0], i_rs2_data[HALF-1:0], 1'b1);
        f3_p1    <= i_funct3;
      end
    end

    // ---- stage 2: merge halves ----
    // Low-half ordering only decides when the upper halves tie.
    always_ff @(posedge i_clk) begin
      if (!i_stall) begin
        eq_p2 <= eq_hi_p1 & eq_lo_p1;
        lt_p2 <= eq_hi_p1 ? lt_lo_p1 : lt_hi_p1;
        f3_p2 <= f3_p1;
      end
    end

    assign res_vld = vld_p2;
    assign res_eq  = eq_p2;
    assign res_lt  = lt_p2;
    assign res_f3  = f3_p2;
  end

  // Outputs are forced to zero whenever the final stage holds no entry.
  assign dec        = resolve(res_f3, res_eq, res_lt);
  assign o_valid    = res_vld;
  assign o_br_equal = res_vld & res_eq;
  assign o_br_less  = res_vld & res_lt;
  assign o_br_taken = res_vld & dec[1];
  assign o_illegal  = res_vld & dec[0];

endmodule

// File: tb/tb_brc_pipe.sv
// tb_brc_pipe: directed checks of brc_pipe with SPLIT=0 and SPLIT=1 side by side.
module tb_brc_pipe;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic        stall;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;

  logic v0, eq0, lt0, tk0, il0;
  logic v1, eq1, lt1, tk1, il1;
  logic [4:0] o0;
  logic [4:0] o1;

  int n_assert;
  int n_fail;

  // Result vectors are {valid, equal, less, taken, illegal}.
  logic [2:0]  t_f3  [13];
  logic [31:0] t_a   [13];
  logic [31:0] t_b   [13];
  logic [4:0]  t_exp [13];

  brc_pipe #(.XLEN(32), .SPLIT(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_stall(stall),
    .i_flush(flush), .i_funct3(funct3), .i_rs1_data(rs1), .i_rs2_data(rs2),
    .o_valid(v0), .o_br_equal(eq0), .o_br_less(lt0), .o_br_taken(tk0),
    .o_illegal(il0)
  );

  brc_pipe #(.XLEN(32), .SPLIT(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_stall(stall),
    .i_flush(flush), .i_funct3(funct3), .i_rs1_data(rs1), .i_rs2_data(rs2),
    .o_valid(v1), .o_br_equal(eq1), .o_br_less(lt1), .o_br_taken(tk1),
    .o_illegal(il1)
  );

  assign o0 = {v0, eq0, lt0, tk0, il0};
  assign o1 = {v1, eq1, lt1, tk1, il1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic st, input logic fl,
                       input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b);
    valid  = v;
    stall  = st;
    flush  = fl;
    funct3 = f3;
    rs1    = a;
    rs2    = b;
  endtask

  task automatic chk(input string tag, input logic [4:0] obs,
                     input logic [4:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;

    t_f3  = '{3'b100, 3'b110, 3'b110, 3'b100, 3'b000, 3'b000, 3'b001,
              3'b100, 3'b101, 3'b110, 3'b111, 3'b011, 3'b010};
    t_a   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0001_0000, 32'h8000_FFFF,
              32'h1234_5678, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000,
              32'h8000_0000, 32'h8000_0000, 32'd3, 32'd1};
    t_b   = '{32'h0000_0001, 32'h0000_0001, 32'h0000_FFFF, 32'h8001_0000,
              32'h1234_5678, 32'd7, 32'd7, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
              32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd3, 32'd2};
    t_exp = '{5'b10110, 5'b10000, 5'b10000, 5'b10110, 5'b11010, 5'b10100,
              5'b10110, 5'b10110, 5'b10100, 5'b10000, 5'b10010, 5'b11001,
              5'b10101};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    tick();
    tick();
    chk("reset_s0", o0, 5'b00000);
    chk("reset_s1", o1, 5'b00000);
    rst_n = 1'b1;
    tick();
    chk("post_reset_s0", o0, 5'b00000);
    chk("post_reset_s1", o1, 5'b00000);

    // Back-to-back stream: SPLIT=1 trails SPLIT=0 by exactly one cycle.
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, 1'b0, 1'b0, t_f3[i], t_a[i], t_b[i]);
      tick();
      chk($sformatf("stream_s0_%0d", i), o0, t_exp[i]);
      chk($sformatf("stream_s1_%0d", i), o1, (i == 0) ? 5'b00000 : t_exp[i-1]);
    end
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    tick();
    chk("drain_s0", o0, 5'b00000);
    chk("drain_s1", o1, t_exp[12]);
    tick();
    chk("empty_s1", o1, 5'b00000);

    // Two entries in flight, then a 3-cycle stall with junk on the inputs.
    drive(1'b1, 1'b0, 1'b0, t_f3[6], t_a[6], t_b[6]);
    tick();
    drive(1'b1, 1'b0, 1'b0, t_f3[9], t_a[9], t_b[9]);
    tick();
    chk("prestall_s0", o0, t_exp[9]);
    chk("prestall_s1", o1, t_exp[6]);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 3'b000, 32'hDEAD_0000 + i, 32'hDEAD_0000 + i);
      tick();
      chk($sformatf("stall_s0_%0d", i), o0, t_exp[9]);
      chk($sformatf("stall_s1_%0d", i), o1, t_exp[6]);
    end
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    tick();
    chk("resume_s0", o0, 5'b00000);
    chk("resume_s1", o1, t_exp[9]);
    tick();
    chk("resume_empty_s1", o1, 5'b00000);

    // Flush together with a valid input drops it and the in-flight entry.
    drive(1'b1, 1'b0, 1'b0, t_f3[4], t_a[4], t_b[4]);
    tick();
    chk("preflush_s0", o0, t_exp[4]);
    drive(1'b1, 1'b0, 1'b1, t_f3[0], t_a[0], t_b[0]);
    tick();
    chk("flush_s0", o0, 5'b00000);
    chk("flush_s1", o1, 5'b00000);
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    tick();
    chk("postflush_s0", o0, 5'b00000);
    chk("postflush_s1", o1, 5'b00000);

    // Flush while stalled overrides the hold.
    drive(1'b1, 1'b0, 1'b0, t_f3[7], t_a[7], t_b[7]);
    tick();
    drive(1'b1, 1'b0, 1'b0, t_f3[10], t_a[10], t_b[10]);
    tick();
    chk("prefs_s1", o1, t_exp[7]);
    drive(1'b1, 1'b1, 1'b1, t_f3[0], t_a[0], t_b[0]);
    tick();
    chk("flushstall_s0", o0, 5'b00000);
    chk("flushstall_s1", o1, 5'b00000);
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    tick();
    chk("postfs_s1", o1, 5'b00000);

    // Asynchronous reset with entries in flight clears outputs at once.
    drive(1'b1, 1'b0, 1'b0, t_f3[11], t_a[11], t_b[11]);
    tick();
    drive(1'b1, 1'b0, 1'b0, t_f3[3], t_a[3], t_b[3]);
    tick();
    chk("prerst_s0", o0, t_exp[3]);
    chk("prerst_s1", o1, t_exp[11]);
    rst_n = 1'b0;
    #1;
    chk("async_rst_s0", o0, 5'b00000);
    chk("async_rst_s1", o1, 5'b00000);
    tick();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_s0", o0, 5'b00000);
    chk("rel_s1", o1, 5'b00000);
    tick();
    chk("rel2_s1", o1, 5'b00000);
    drive(1'b1, 1'b0, 1'b0, t_f3[8], t_a[8], t_b[8]);
    tick();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    chk("new_s0", o0, t_exp[8]);
    chk("new_s1_wait", o1, 5'b00000);
    tick();
    chk("new_s1", o1, t_exp[8]);
    chk("new_s0_done", o0, 5'b00000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
